// File: rtl/fft_mul_share_arb_if.sv
// Bus bundle for the shared FFT multiplier arbiter: requester side,
// DSP operand/product pins and the single valid/ready product port.
interface fft_mul_share_arb_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*18-1:0] req_a;
    logic [NUM_REQ*15-1:0] req_b;
    logic                  mul_ce;
    logic [17:0]           mul_din0;
    logic [14:0]           mul_din1;
    logic [32:0]           mul_dout;
    logic                  out_valid;
    logic                  out_ready;
    logic [32:0]           out_data;
    logic [ID_W-1:0]       out_id;
    logic                  busy;

    modport slave (
        input  req_valid, req_a, req_b, mul_dout, out_ready,
        output req_ready, mul_ce, mul_din0, mul_din1,
        output out_valid, out_data, out_id, busy
    );

    modport master (
        output req_valid, req_a, req_b, mul_dout, out_ready,
        input  req_ready, mul_ce, mul_din0, mul_din1,
        input  out_valid, out_data, out_id, busy
    );
endinterface

// File: rtl/fft_mul_share_arb.sv
// Round-robin sharing of one 2-cycle signed x unsigned DSP multiplier
// between NUM_REQ requesters; IDs ride alongside, backpressure via ce.
module fft_mul_share_arb #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int MUL_LAT = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    fft_mul_share_arb_if.slave bus
);
    logic [MUL_LAT-1:0] r_vld;
    logic [ID_W-1:0]    r_id [MUL_LAT];
    logic [ID_W-1:0]    r_ptr;

    logic            w_stall;
    logic            w_ce;
    logic            w_found;
    logic            w_acc;
    logic [ID_W-1:0] w_gnt;
    logic [ID_W-1:0] w_ptr_nxt;

    // Only the product at the output can stall, so a full pipe drains
    // and refills without bubbles.
    assign w_stall = r_vld[MUL_LAT-1] & ~bus.out_ready;
    assign w_ce    = ~w_stall;
    assign w_acc   = w_found & w_ce;

    always_comb begin : arb
        int idx;
        idx     = 0;
        w_found = 1'b0;
        w_gnt   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(r_ptr) + k) % NUM_REQ;
            if (!w_found && bus.req_valid[idx]) begin
                w_found = 1'b1;
                w_gnt   = ID_W'(idx);
            end
        end
    end

    always_comb begin
        bus.req_ready = '0;
        if (w_found)
            bus.req_ready[w_gnt] = w_ce;
    end

    assign w_ptr_nxt = (w_gnt == ID_W'(NUM_REQ - 1)) ? '0
                                                     : w_gnt + ID_W'(1);

    // Idle operands are forced to zero so the DSP inputs stay deterministic.
    assign bus.mul_din0 = w_found ? bus.req_a[int'(w_gnt)*18 +: 18] : '0;
    assign bus.mul_din1 = w_found ? bus.req_b[int'(w_gnt)*15 +: 15] : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_vld <= '0;
            r_ptr <= '0;
            for (int k = 0; k < MUL_LAT; k++)
                r_id[k] <= '0;
        end else if (w_ce) begin
            r_vld[0] <= w_acc;
            r_id[0]  <= w_gnt;
            for (int k = 1; k < MUL_LAT; k++) begin
                r_vld[k] <= r_vld[k-1];
                r_id[k]  <= r_id[k-1];
            end
            if (w_acc)
                r_ptr <= w_ptr_nxt;
        end
    end

    assign bus.mul_ce    = w_ce;
    assign bus.out_valid = r_vld[MUL_LAT-1];
    assign bus.out_id    = r_id[MUL_LAT-1];
    assign bus.out_data  = bus.mul_dout;
    assign bus.busy      = |r_vld;
endmodule

// File: tb/tb_fft_mul_share_arb.sv
// Bench for fft_mul_share_arb: directed scenarios plus random traffic
// against a queue-based reference of grants, products and latency.
module tb_fft_mul_share_arb;
    localparam int N = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    fft_mul_share_arb_if #(.NUM_REQ(N), .ID_W(2)) bus ();

    fft_mul_share_arb #(.NUM_REQ(N), .ID_W(2), .MUL_LAT(2)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Stand-in for the DSP: two ce-gated registers, no reset.
    logic signed [32:0] dsp_p1, dsp_p2;
    always @(posedge clk) begin
        if (bus.mul_ce) begin
            dsp_p1 <= 33'($signed(bus.mul_din0) * $signed({1'b0, bus.mul_din1}));
            dsp_p2 <= dsp_p1;
        end
    end
    assign bus.mul_dout = dsp_p2;

    typedef struct {
        int     id;
        longint p;
        int     rem;
    } ent_t;

    ent_t q[$];
    logic signed [17:0] ta [N];
    logic [14:0]        tbv [N];
    logic [N-1:0]       tv;
    int ptr_m;
    int mode;
    int n_vec;
    int n_err;
    bit found_m;
    bit stall_m;
    int g_m;
    logic [32:0] kval;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic apply();
        for (int i = 0; i < N; i++) begin
            bus.req_a[i*18 +: 18] = ta[i];
            bus.req_b[i*15 +: 15] = tbv[i];
        end
        bus.req_valid = tv;
    endtask

    task automatic new_ops(int i);
        ta[i]  = 18'($urandom);
        tbv[i] = 15'($urandom);
    endtask

    task automatic check();
        logic [N-1:0] er;
        bit ov;
        longint hp;
        ov = (q.size() > 0) && (q[0].rem == 0);
        stall_m = ov && !bus.out_ready;
        found_m = 1'b0;
        g_m = 0;
        for (int k = 0; k < N; k++) begin
            int i;
            i = (ptr_m + k) % N;
            if (!found_m && tv[i]) begin
                found_m = 1'b1;
                g_m = i;
            end
        end
        er = '0;
        if (found_m && !stall_m) er[g_m] = 1'b1;
        chk("req_ready", bus.req_ready, er);
        chk("mul_ce", bus.mul_ce, !stall_m);
        chk("out_valid", bus.out_valid, ov);
        chk("busy", bus.busy, q.size() > 0);
        chk("din0", bus.mul_din0, found_m ? ta[g_m] : 18'h0);
        chk("din1", bus.mul_din1, found_m ? tbv[g_m] : 15'h0);
        if (ov) begin
            hp = q[0].p;
            chk("out_id", bus.out_id, q[0].id);
            chk("out_data", bus.out_data, hp[32:0]);
        end
    endtask

    task automatic update();
        if (!stall_m) begin
            if (q.size() > 0 && q[0].rem == 0) void'(q.pop_front());
            foreach (q[j]) if (q[j].rem > 0) q[j].rem--;
            if (found_m) begin
                ent_t e;
                e.id  = g_m;
                e.p   = longint'(ta[g_m]) * longint'(tbv[g_m]);
                e.rem = 1;
                q.push_back(e);
                ptr_m = (g_m + 1) % N;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!stall_m && found_m && i == g_m) begin
                new_ops(i);
                tv[i] = (mode == 2) ? 1'b1 :
                        (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            end else if (mode == 1 && !tv[i]) begin
                new_ops(i);
                tv[i] = 1'($urandom_range(0, 1));
            end
        end
    endtask

    task automatic cycle();
        apply();
        @(negedge clk);
        check();
        @(posedge clk);
        update();
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        mode = 0;
        ptr_m = 0;
        tv = '0;
        for (int i = 0; i < N; i++) begin
            ta[i] = '0;
            tbv[i] = '0;
        end
        bus.out_ready = 1'b1;
        apply();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_id", bus.out_id, 0);
        chk("rst_ready", bus.req_ready, 0);
        reset_n = 1'b1;

        // single request, -3 * 5
        ta[0] = -18'sd3;
        tbv[0] = 15'd5;
        tv = 4'b0001;
        cycle();
        cycle();
        chk("t1_valid", bus.out_valid, 1);
        chk("t1_data", bus.out_data, 33'h1FFFFFFF1);
        chk("t1_id", bus.out_id, 0);
        cycle();
        chk("t1_once", bus.out_valid, 0);
        cycle();

        // two accepts then asynchronous reset
        tv = 4'b0011;
        new_ops(0);
        new_ops(1);
        cycle();
        cycle();
        #2 reset_n = 1'b0;
        #1;
        chk("t6_valid", bus.out_valid, 0);
        chk("t6_busy", bus.busy, 0);
        chk("t6_id", bus.out_id, 0);
        q.delete();
        ptr_m = 0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (3) cycle();

        // all four requesters streaming
        mode = 2;
        tv = 4'b1111;
        for (int i = 0; i < N; i++) new_ops(i);
        apply();
        #1;
        chk("t6_first", bus.req_ready, 4'b0001);
        repeat (16) cycle();
        mode = 0;
        repeat (8) cycle();

        // backpressure on a req2 stream
        mode = 2;
        tv = 4'b0100;
        new_ops(2);
        repeat (3) cycle();
        bus.out_ready = 1'b0;
        repeat (3) cycle();
        bus.out_ready = 1'b1;
        repeat (4) cycle();
        mode = 0;
        repeat (4) cycle();

        // fairness: req1 alone leaves ptr at 2
        tv = 4'b0010;
        new_ops(1);
        cycle();
        repeat (3) cycle();
        tv = 4'b1010;
        new_ops(1);
        new_ops(3);
        apply();
        #1;
        chk("t5_first", bus.req_ready, 4'b1000);
        cycle();
        apply();
        #1;
        chk("t5_second", bus.req_ready, 4'b0010);
        cycle();
        repeat (3) cycle();
        tv = 4'b1111;
        apply();
        #1;
        chk("t5_ptr", bus.req_ready, 4'b0100);
        repeat (8) cycle();

        // operand extremes
        ta[0] = -18'sd131072;
        tbv[0] = 15'd32767;
        tv = 4'b0001;
        cycle();
        ta[0] = 18'sd131071;
        tbv[0] = 15'd32767;
        tv = 4'b0001;
        cycle();
        kval = -33'sd4294836224;
        chk("t4_min", bus.out_data, kval);
        cycle();
        kval = 33'sd4294803457;
        chk("t4_max", bus.out_data, kval);
        repeat (3) cycle();

        // random traffic with random backpressure
        mode = 1;
        repeat (400) begin
            bus.out_ready = ($urandom_range(0, 9) < 7);
            cycle();
        end
        mode = 0;
        bus.out_ready = 1'b1;
        repeat (12) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
